// File: rtl/pulse_counter_pkg.sv
// pulse_counter_pkg: shared encodings for the multi-channel pulse counter
package pulse_counter_pkg;
  typedef enum logic [1:0] {
    EDGE_RISE = 2'b00,
    EDGE_FALL = 2'b01,
    EDGE_BOTH = 2'b10,
    EDGE_NONE = 2'b11
  } edge_mode_e;
  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;
  localparam logic SAT_WRAP = 1'b0;
  localparam logic SAT_HOLD = 1'b1;
endpackage

// File: rtl/pulse_counter_ch.sv
// pulse_counter_ch: one channel - synchroniser, edge qualifier, up/down counter, sticky ovf, window accumulator
module pulse_counter_ch
  import pulse_counter_pkg::*;
#(
  parameter int CW          = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pulse_i,
  input  logic          armed_i,
  input  logic          en_i,
  input  logic          ud_i,
  input  logic          clr_i,
  input  logic          pre_i,
  input  logic [CW-1:0] pre_val_i,
  input  edge_mode_e    edge_mode_i,
  input  logic          sat_mode_i,
  input  logic          win_en_i,
  input  logic          term_i,
  input  logic          ovf_clr_i,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] snap_o,
  output logic          ovf_o
);
  localparam logic [CW-1:0] MAX = '1;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q, ovf_q, ovf_d;
  logic [CW-1:0]          count_q, count_d, snap_q, snap_d, acc_q, acc_d;
  logic                   lvl, rise, fall, qual, ev, at_lim, ofl;
  logic [CW-1:0]          step, acc_inc;
  always_comb begin
    lvl     = sync_q[SYNC_STAGES-1];
    rise    = lvl & ~prev_q;
    fall    = ~lvl & prev_q;
    qual    = (edge_mode_i == EDGE_RISE) ? rise :
              (edge_mode_i == EDGE_FALL) ? fall :
              (edge_mode_i == EDGE_BOTH) ? (rise | fall) : 1'b0;
    ev      = qual & en_i & armed_i;
    at_lim  = (ud_i == DIR_UP) ? (count_q == MAX) : (count_q == '0);
    step    = (ud_i == DIR_UP) ? count_q + CW'(1) : count_q - CW'(1);
    ofl     = ev & ~clr_i & ~pre_i & at_lim;
    count_d = clr_i ? '0 :
              pre_i ? pre_val_i :
              ev    ? ((at_lim && sat_mode_i == SAT_HOLD) ? count_q : step) : count_q;
    ovf_d   = clr_i ? 1'b0 : ofl ? 1'b1 : ovf_clr_i ? 1'b0 : ovf_q;
    // window count ignores direction and preset, and saturates rather than wraps
    acc_inc = (ev && acc_q != MAX) ? acc_q + CW'(1) : acc_q;
    snap_d  = term_i ? acc_inc : snap_q;
    acc_d   = (clr_i || !win_en_i || term_i) ? '0 : acc_inc;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      prev_q  <= 1'b0;
      count_q <= '0;
      snap_q  <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pulse_i};
      prev_q  <= lvl;
      count_q <= count_d;
      snap_q  <= snap_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end
  assign count_o = count_q;
  assign snap_o  = snap_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/pulse_counter_mc.sv
// pulse_counter_mc: N-channel encoder pulse counter with shared gate-window frequency snapshots
module pulse_counter_mc
  import pulse_counter_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int COUNT_WIDTH = 16,
  parameter int WIN_WIDTH   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_CH-1:0]             pulse_in,
  input  logic [N_CH-1:0]             en,
  input  logic [N_CH-1:0]             ud,
  input  logic [N_CH-1:0]             clr,
  input  logic [N_CH-1:0]             pre,
  input  logic [N_CH*COUNT_WIDTH-1:0] pre_val,
  input  logic [1:0]                  edge_mode,
  input  logic                        sat_mode,
  input  logic [WIN_WIDTH-1:0]        win_len,
  input  logic                        ovf_clr,
  output logic [N_CH*COUNT_WIDTH-1:0] count_q,
  output logic [N_CH*COUNT_WIDTH-1:0] snap_q,
  output logic                        snap_valid,
  output logic [N_CH-1:0]             ovf
);
  localparam int ARM = SYNC_STAGES + 1;
  localparam int AW  = $clog2(ARM + 1);
  logic [AW-1:0]        arm_q, arm_d;
  logic [WIN_WIDTH-1:0] timer_q, timer_d;
  logic                 valid_q, armed, win_en, term;
  // edges are masked until the synchroniser holds only post-reset samples
  always_comb begin
    armed   = (arm_q == AW'(ARM));
    arm_d   = armed ? arm_q : arm_q + AW'(1);
    win_en  = (win_len != '0);
    term    = win_en && (timer_q >= win_len - WIN_WIDTH'(1));
    timer_d = (!win_en || term) ? '0 : timer_q + WIN_WIDTH'(1);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      arm_q   <= '0;
      timer_q <= '0;
      valid_q <= 1'b0;
    end else begin
      arm_q   <= arm_d;
      timer_q <= timer_d;
      valid_q <= term;
    end
  end
  assign snap_valid = valid_q;
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    pulse_counter_ch #(.CW(COUNT_WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pulse_i    (pulse_in[i]),
      .armed_i    (armed),
      .en_i       (en[i]),
      .ud_i       (ud[i]),
      .clr_i      (clr[i]),
      .pre_i      (pre[i]),
      .pre_val_i  (pre_val[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .edge_mode_i(edge_mode_e'(edge_mode)),
      .sat_mode_i (sat_mode),
      .win_en_i   (win_en),
      .term_i     (term),
      .ovf_clr_i  (ovf_clr),
      .count_o    (count_q[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .snap_o     (snap_q[i*COUNT_WIDTH +: COUNT_WIDTH]),
      .ovf_o      (ovf[i])
    );
  end
endmodule

// File: tb/tb_pulse_counter_mc.sv
// tb_pulse_counter_mc: directed table plus randomized run checked against an arithmetic reference model
module tb_pulse_counter_mc;
  logic        clk = 1'b0;
  logic        rst, sat_mode, ovf_clr, snap_valid;
  logic [3:0]  pulse_in, en, ud, clr, pre, ovf;
  logic [63:0] pre_val, count_q, snap_q;
  logic [1:0]  edge_mode;
  logic [23:0] win_len;
  int total = 0, bad = 0;
  bit chk_on = 0;
  pulse_counter_mc dut (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .en(en), .ud(ud), .clr(clr), .pre(pre),
    .pre_val(pre_val), .edge_mode(edge_mode), .sat_mode(sat_mode), .win_len(win_len),
    .ovf_clr(ovf_clr), .count_q(count_q), .snap_q(snap_q), .snap_valid(snap_valid), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask
  // reference model: pulse history per channel, integer counters, window from the timing rules
  int mc[4], ma[4], ms[4];
  bit mo[4], h1[4], h2[4], h3[4];
  bit msv;
  int n_rel, mt;
  always @(posedge clk) begin
    bit term, ev, of, lvl, prv;
    int lim;
    if (rst) begin
      n_rel = 0; mt = 0; msv = 0;
      for (int i = 0; i < 4; i++) begin
        mc[i] = 0; ma[i] = 0; ms[i] = 0; mo[i] = 0; h1[i] = 0; h2[i] = 0; h3[i] = 0;
      end
    end else begin
      if (n_rel < 100) n_rel++;
      term = (win_len != 0) && (mt >= int'(win_len) - 1);
      for (int i = 0; i < 4; i++) begin
        lvl = h2[i]; prv = h3[i];
        ev = (n_rel >= 4) && en[i] &&
             (edge_mode == 2'b00 ? (lvl && !prv) :
              edge_mode == 2'b01 ? (!lvl && prv) :
              edge_mode == 2'b10 ? (lvl != prv) : 1'b0);
        of = 0;
        lim = ud[i] ? 0 : 65535;
        if (clr[i]) mc[i] = 0;
        else if (pre[i]) mc[i] = int'(pre_val[i*16 +: 16]);
        else if (ev) begin
          if (mc[i] == lim) begin
            of = 1;
            mc[i] = sat_mode ? lim : 65535 - lim;
          end else mc[i] = ud[i] ? mc[i] - 1 : mc[i] + 1;
        end
        if (clr[i]) mo[i] = 0;
        else if (of) mo[i] = 1;
        else if (ovf_clr) mo[i] = 0;
        if (term) ms[i] = (ma[i] + int'(ev) > 65535) ? 65535 : ma[i] + int'(ev);
        if (clr[i] || win_len == 0 || term) ma[i] = 0;
        else if (ev && ma[i] < 65535) ma[i]++;
        h3[i] = h2[i]; h2[i] = h1[i]; h1[i] = pulse_in[i];
      end
      msv = term;
      mt = (win_len == 0 || term) ? 0 : mt + 1;
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("mdl_count%0d", i), 32'(count_q[i*16 +: 16]), 32'(mc[i]));
        check($sformatf("mdl_snap%0d", i), 32'(snap_q[i*16 +: 16]), 32'(ms[i]));
        check($sformatf("mdl_ovf%0d", i), 32'(ovf[i]), 32'(mo[i]));
      end
      check("mdl_snap_valid", 32'(snap_valid), 32'(msv));
    end
  end
  task automatic cyc(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic pulse(input int ch, input int hi, input int lo);
    pulse_in[ch] = 1'b1;
    cyc(hi);
    pulse_in[ch] = 1'b0;
    cyc(lo);
  endtask
  typedef struct {
    logic [1:0]  em;
    logic        dn;
    logic        sat;
    logic        do_pre;
    logic [15:0] pv;
    int          np;
    logic [15:0] exp_cnt;
    logic        exp_ovf;
  } vec_t;
  vec_t tbl[6];
  initial begin
    int strobes, last_t;
    tbl[0] = '{2'b10, 1'b0, 1'b0, 1'b0, 16'h0000, 5, 16'd10, 1'b0};
    tbl[1] = '{2'b01, 1'b0, 1'b0, 1'b0, 16'h0000, 5, 16'd15, 1'b0};
    tbl[2] = '{2'b00, 1'b0, 1'b0, 1'b1, 16'hFFFE, 3, 16'h0001, 1'b1};
    tbl[3] = '{2'b00, 1'b0, 1'b1, 1'b1, 16'hFFFE, 3, 16'hFFFF, 1'b1};
    tbl[4] = '{2'b00, 1'b1, 1'b0, 1'b1, 16'h0002, 3, 16'hFFFF, 1'b1};
    tbl[5] = '{2'b11, 1'b0, 1'b0, 1'b1, 16'h0100, 4, 16'h0100, 1'b0};
    rst = 1; pulse_in = 4'b0001; en = 4'b1111; ud = 0; clr = 0; pre = 0; pre_val = 0;
    edge_mode = 2'b00; sat_mode = 0; win_len = 0; ovf_clr = 0;
    cyc(3);
    chk_on = 1;
    check("rst_count", count_q[31:0], 32'h0);
    check("rst_snap", snap_q[31:0], 32'h0);
    check("rst_ovf", 32'(ovf), 32'h0);
    check("rst_valid", 32'(snap_valid), 32'h0);
    rst = 0;
    cyc(10);
    check("arm_mask", 32'(count_q[15:0]), 32'h0);
    pulse_in[0] = 0;
    cyc(5);
    for (int v = 0; v < 6; v++) begin
      edge_mode = tbl[v].em; ud[0] = tbl[v].dn; sat_mode = tbl[v].sat;
      if (tbl[v].do_pre) begin
        pre_val[15:0] = tbl[v].pv; pre[0] = 1; ovf_clr = 1;
        cyc(1);
        pre[0] = 0; ovf_clr = 0;
      end
      for (int p = 0; p < tbl[v].np; p++) pulse(0, 2, 4);
      cyc(2);
      check($sformatf("tbl%0d_count", v), 32'(count_q[15:0]), 32'(tbl[v].exp_cnt));
      check($sformatf("tbl%0d_ovf", v), 32'(ovf[0]), 32'(tbl[v].exp_ovf));
    end
    edge_mode = 2'b00; ud[0] = 1; sat_mode = 0; pre_val[15:0] = 0; pre[0] = 1; ovf_clr = 1;
    cyc(1);
    pre[0] = 0; ovf_clr = 0;
    cyc(1);
    pulse_in[0] = 1;
    cyc(2);
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    check("under_count", 32'(count_q[15:0]), 32'h0000FFFF);
    check("under_ovf_wins", 32'(ovf[0]), 32'h1);
    pulse_in[0] = 0;
    cyc(1);
    ovf_clr = 1;
    cyc(1);
    ovf_clr = 0;
    check("ovf_clr", 32'(ovf[0]), 32'h0);
    cyc(4);
    en = 4'b0010; ud = 0; win_len = 24'd100; strobes = 0; last_t = -1;
    for (int t = 0; t < 305; t++) begin
      pulse_in[1] = (t % 10 == 0);
      @(negedge clk);
      if (snap_valid) begin
        strobes++;
        check("win_snap1", 32'(snap_q[31:16]), 32'd10);
        if (last_t >= 0) check("win_period", 32'(t - last_t), 32'd100);
        last_t = t;
      end
    end
    check("win_strobes", 32'(strobes), 32'd3);
    win_len = 0; strobes = 0;
    for (int t = 0; t < 250; t++) begin
      pulse_in[1] = (t % 10 == 0);
      @(negedge clk);
      if (snap_valid) strobes++;
    end
    check("win_off_strobes", 32'(strobes), 32'd0);
    check("win_off_hold", 32'(snap_q[31:16]), 32'd10);
    pulse_in[1] = 0;
    en = 4'b0100; win_len = 24'd1000; sat_mode = 0;
    pre_val[47:32] = 16'hFFFF; pre[2] = 1;
    cyc(1);
    pre[2] = 0;
    pulse(2, 2, 4);
    check("ch2_ovf_set", 32'(ovf[2]), 32'h1);
    pulse_in[2] = 1;
    cyc(2);
    clr[2] = 1; pre[2] = 1; pre_val[47:32] = 16'h5555;
    cyc(1);
    clr[2] = 0; pre[2] = 0;
    check("clrpre_count", 32'(count_q[47:32]), 32'h0);
    check("clrpre_ovf", 32'(ovf[2]), 32'h0);
    check("clrpre_ch0", 32'(count_q[15:0]), 32'h0000FFFF);
    pulse_in[2] = 0;
    cyc(4);
    win_len = 24'd1;
    cyc(1);
    check("clrpre_acc", 32'(snap_q[47:32]), 32'h0);
    check("win1_valid", 32'(snap_valid), 32'h1);
    for (int t = 0; t < 2000; t++) begin
      pulse_in = 4'($urandom); en = 4'($urandom); ud = 4'($urandom);
      for (int c = 0; c < 4; c++) begin
        clr[c] = ($urandom_range(31) == 0);
        pre[c] = ($urandom_range(15) == 0);
        case ($urandom_range(3))
          0: pre_val[c*16 +: 16] = 16'hFFFF;
          1: pre_val[c*16 +: 16] = 16'hFFFE;
          2: pre_val[c*16 +: 16] = 16'(c & 1);
          default: pre_val[c*16 +: 16] = 16'($urandom);
        endcase
      end
      ovf_clr = ($urandom_range(19) == 0);
      if ($urandom_range(49) == 0) edge_mode = 2'($urandom);
      if ($urandom_range(99) == 0) sat_mode = ~sat_mode;
      if ($urandom_range(60) == 0) win_len = 24'($urandom_range(13));
      rst = (t >= 1000 && t < 1002);
      @(negedge clk);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
